// File: rtl/permutation_sequencer.sv
// Round sequencer for an external iterative permutation core: accepts a state,
// steps the core through p^a or p^b round indices, captures and holds the result.
module permutation_sequencer #(
    parameter int ROUNDS_A = 12,
    parameter int ROUNDS_B = 6
) (
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic         start_valid_i,
    output logic         start_ready_o,
    input  logic [319:0] state_i,
    input  logic         rounds_b_i,
    output logic [319:0] perm_state_o,
    output logic         perm_select_o,
    output logic [3:0]   perm_round_o,
    input  logic [319:0] perm_state_i,
    output logic         result_valid_o,
    input  logic         result_ready_i,
    output logic [319:0] state_o,
    output logic         busy_o
);

    // state | meaning
    // IDLE  | waiting for an input state, start_ready_o high
    // RUN   | one core round per cycle, round index = counter
    // CAPT  | core output settled; registered into the output register
    // DONE  | result held on state_o until the consumer takes it
    typedef enum logic [1:0] {IDLE, RUN, CAPT, DONE} state_e;

    localparam logic [3:0] START_A    = 4'(12 - ROUNDS_A);
    localparam logic [3:0] START_B    = 4'(12 - ROUNDS_B);
    localparam logic [3:0] LAST_ROUND = 4'd11;

    state_e       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         first_q, first_d;
    logic [319:0] in_q, in_d;
    logic [319:0] out_q, out_d;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            first_q <= 1'b0;
            in_q    <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            in_q    <= in_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        first_d        = first_q;
        in_d           = in_q;
        out_d          = out_q;
        start_ready_o  = 1'b0;
        busy_o         = 1'b1;
        result_valid_o = 1'b0;
        perm_select_o  = 1'b0;
        perm_round_o   = 4'd0;
        case (state_q)
            IDLE: begin
                start_ready_o = 1'b1;
                busy_o        = 1'b0;
                if (start_valid_i) begin
                    in_d    = state_i;
                    cnt_d   = rounds_b_i ? START_B : START_A;
                    first_d = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                perm_round_o  = cnt_q;
                perm_select_o = first_q;
                first_d       = 1'b0;
                // Counter parks at 0 after the last round so it never passes 11.
                if (cnt_q == LAST_ROUND) begin
                    cnt_d   = 4'd0;
                    state_d = CAPT;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            CAPT: begin
                out_d   = perm_state_i;
                state_d = DONE;
            end
            DONE: begin
                result_valid_o = 1'b1;
                if (result_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign perm_state_o = in_q;
    assign state_o      = out_q;

endmodule
